lsu: RTL and testbench
======================

# lsu

Load/store unit: the initiator side of the data-memory port. Accepts one load or store at a time from the execute stage and drives the memory interface (`valid`, `wen_m`, `wmask`, `waddr`, `wdata`, `raddr`/`rdata`) for a programmable number of cycles. For loads it aligns and sign/zero-extends the read word; for stores it builds the byte-lane mask and the shifted write data. It then returns a one-cycle response to the pipeline. Sits between EXU and the data-memory responder.

## Interface
- `ACCESS_CYCLES`, default 1: cycles `mem_valid` is held per access (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request (high only in IDLE).
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: formatted load data; 0 for stores and errors.
- `resp_err` out 1: misaligned address or illegal funct3; qualified by `resp_valid`.
- `mem_valid` out 1: memory access request.
- `mem_wen` out 1: write enable, only while `mem_valid`.
- `mem_wmask` out 8: byte-lane mask; bits [7:4] always 0.
- `mem_waddr` out 32: word-aligned write address (`addr & ~3`).
- `mem_raddr` out 32: word-aligned read address (`addr & ~3`).
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: combinational read word, valid in the same cycle as `mem_valid`.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: `req_ready=1`. When `req_valid`, the request is registered.
  - If the request is illegal or misaligned, go to DONE with err=1.
  - Otherwise go to ACCESS and load the counter with `ACCESS_CYCLES-1`.
- ACCESS:
  - `mem_valid=1`; `mem_wen=req_is_store`.
  - Addresses, mask and data come from the registered request and are stable for the whole access.
  - Counter decrements each cycle. At counter==0, loads latch formatted `mem_rdata`, then go to DONE.
- DONE: `resp_valid=1` for exactly one cycle, then go to IDLE. No new request is accepted in DONE.
- Misaligned: LH/LHU/SH with `addr[0]=1`; LW/SW with `addr[1:0]≠0`.
- Illegal: load funct3 011/110/111, or store funct3 other than 000/001/010.
- Error requests never assert `mem_valid`.
- Load formatting, with `off=addr[1:0]`:
  - byte = `rdata[8*off+:8]`; half = `rdata[16*off[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store formatting:
  - SB: mask `0001<<off`; data `{4{wdata[7:0]}}`.
  - SH: mask `0011<<off`; data `{2{wdata[15:0]}}`.
  - SW: mask `1111`; data = `wdata`.
- Outside ACCESS, all `mem_*` outputs are 0.

## Timing
- Reset values: state IDLE; `req_ready=1`; `resp_valid=0`; `resp_rdata=0`; `resp_err=0`; every `mem_*` output 0; counter 0.
- Normal latency: accept at cycle 0, ACCESS for cycles 1..N (N=`ACCESS_CYCLES`), `resp_valid` at cycle N+1. Next accept is possible at cycle N+2.
- Error latency: accept at cycle 0, `resp_valid` with err at cycle 1.
- `rst` in any state: IDLE on the next edge, all outputs return to reset values, and the in-flight request is dropped with no response. A store aborted in ACCESS may already have written.
- `req_*` is sampled only when `req_valid && req_ready`; changes at other times are ignored.
- `resp_rdata`/`resp_err` are registered and change only on entry to DONE. They are held until the next DONE and are meaningful only with `resp_valid`.

## Structure
- Shared `defines.v` holds:
  - `RegBus`.
  - Funct3 constants: `LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`.
  - LSU state encodings `LSU_IDLE`, `LSU_ACCESS`, `LSU_DONE`.
- Sub-module `lsu_fmt` (combinational): inputs are funct3, `addr[1:0]`, `wdata`, `rdata`; outputs are `wmask`, shifted `wdata`, formatted `rdata`, `misalign`, `illegal`.
- The `lsu` top holds the FSM, counter and request/response registers.

## Test plan
- LW `addr=0x8000_0004`, mem word `0xDEAD_BEEF`, `ACCESS_CYCLES=1`:
  - `mem_valid` is high for exactly cycle 1 with `raddr=0x8000_0004`.
  - Cycle 2: `resp_valid=1`, `resp_rdata=0xDEAD_BEEF`, `err=0`.
- LB vs LBU at `addr=0x8000_0003`, word `0x80xx_xxxx`:
  - LB returns `0xFFFF_FF80`.
  - LBU returns `0x0000_0080`.
- SH `addr=0x8000_0002`, `wdata=0x1234_ABCD`:
  - `mem_wen=1`, `wmask=0x0C`, `mem_wdata=0xABCD_ABCD`, `waddr=0x8000_0000`.
  - Response has `rdata=0`.
- LW at `addr=0x8000_0001`:
  - `mem_valid` is never asserted.
  - Cycle 1: `resp_valid=1`, `err=1`.
  - Repeat with load funct3=011: same result.
- `ACCESS_CYCLES=3`, SW:
  - `mem_valid` high cycles 1–3 with stable address, mask and data.
  - `resp_valid` at cycle 4; `req_ready` low for cycles 1–4.
- Assert `rst` during cycle 2 of a 3-cycle load:
  - Next cycle: IDLE, `mem_valid=0`, no `resp_valid`, `req_ready=1`.
  - A new LW then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned REG_BUS = 32;

  // RV32 funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data-memory port between the LSU (master) and the memory responder (slave).
interface lsu_if import lsu_pkg::*;;
  logic               mem_valid;
  logic               mem_wen;
  logic [7:0]         mem_wmask;
  logic [REG_BUS-1:0] mem_waddr;
  logic [REG_BUS-1:0] mem_raddr;
  logic [REG_BUS-1:0] mem_wdata;
  logic [REG_BUS-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_wmask, mem_waddr, mem_raddr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid, mem_wen, mem_wmask, mem_waddr, mem_raddr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_fmt.sv
// Combinational load/store formatting: lane mask, shifted store data,
// aligned/extended load data, and misalignment / illegal-funct3 detection.
module lsu_fmt import lsu_pkg::*; (
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [1:0]         off,
  input  logic [REG_BUS-1:0] wdata,
  input  logic [REG_BUS-1:0] rdata,
  output logic [7:0]         wmask,
  output logic [REG_BUS-1:0] wdata_sh,
  output logic [REG_BUS-1:0] rdata_fmt,
  output logic               misalign,
  output logic               illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed byte/half and extend it
  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    half_sel  = rdata[{off[1], 4'b0000} +: 16];
    rdata_fmt = '0;
    case (funct3)
      F3_LB:   rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_fmt = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_fmt = rdata;
      F3_LBU:  rdata_fmt = {24'h000000, byte_sel};
      F3_LHU:  rdata_fmt = {16'h0000, half_sel};
      default: rdata_fmt = '0;
    endcase
  end

  // Store path: byte-lane mask and replicated data
  always_comb begin
    wmask    = '0;
    wdata_sh = '0;
    case (funct3)
      F3_SB: begin
        wmask    = {4'b0000, 4'b0001 << off};
        wdata_sh = {4{wdata[7:0]}};
      end
      F3_SH: begin
        wmask    = {4'b0000, 4'b0011 << off};
        wdata_sh = {2{wdata[15:0]}};
      end
      F3_SW: begin
        wmask    = 8'h0F;
        wdata_sh = wdata;
      end
      default: begin
        wmask    = '0;
        wdata_sh = '0;
      end
    endcase
  end

  // Request legality checks
  always_comb begin
    misalign = 1'b0;
    illegal  = 1'b0;
    if (is_store)
      illegal = (funct3 != F3_SB) && (funct3 != F3_SH) && (funct3 != F3_SW);
    else
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    if (!illegal) begin
      if (funct3[1:0] == 2'b01)
        misalign = off[0];
      else if (funct3[1:0] == 2'b10)
        misalign = (off != 2'b00);
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, drives the data-memory
// port for ACCESS_CYCLES cycles, and returns a one-cycle response.
module lsu import lsu_pkg::*; #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_is_store,
  input  logic [2:0]         req_funct3,
  input  logic [REG_BUS-1:0] req_addr,
  input  logic [REG_BUS-1:0] req_wdata,
  output logic               resp_valid,
  output logic [REG_BUS-1:0] resp_rdata,
  output logic               resp_err,
  lsu_if.master              mem
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  lsu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               store_q;
  logic [2:0]         funct3_q;
  logic [REG_BUS-1:0] addr_q;
  logic [REG_BUS-1:0] wdata_q;
  logic [REG_BUS-1:0] resp_rdata_q;
  logic               resp_err_q;

  logic               idle, in_access;
  logic               fmt_store;
  logic [2:0]         fmt_funct3;
  logic [1:0]         fmt_off;
  logic [REG_BUS-1:0] fmt_wdata;
  logic [7:0]         wmask;
  logic [REG_BUS-1:0] wdata_sh, rdata_fmt;
  logic               misalign, illegal;

  assign idle      = (state_q == LSU_IDLE);
  assign in_access = (state_q == LSU_ACCESS);

  // One formatter serves both phases: in IDLE it checks the incoming request,
  // otherwise it formats the registered one.
  assign fmt_store  = idle ? req_is_store    : store_q;
  assign fmt_funct3 = idle ? req_funct3      : funct3_q;
  assign fmt_off    = idle ? req_addr[1:0]   : addr_q[1:0];
  assign fmt_wdata  = idle ? req_wdata       : wdata_q;

  lsu_fmt u_fmt (
    .is_store  (fmt_store),
    .funct3    (fmt_funct3),
    .off       (fmt_off),
    .wdata     (fmt_wdata),
    .rdata     (mem.mem_rdata),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_fmt (rdata_fmt),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (req_valid) state_d = (misalign || illegal) ? LSU_DONE : LSU_ACCESS;
      LSU_ACCESS: if (cnt_q == '0) state_d = LSU_DONE;
      LSU_DONE:   state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  // Request capture, access counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid) begin
            store_q  <= req_is_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (misalign || illegal) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              cnt_q <= CNT_W'(ACCESS_CYCLES - 1);
            end
          end
        end
        LSU_ACCESS: begin
          if (cnt_q == '0) begin
            resp_rdata_q <= store_q ? '0 : rdata_fmt;
            resp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state_q == LSU_DONE);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign mem.mem_valid = in_access;
  assign mem.mem_wen   = in_access & store_q;
  assign mem.mem_wmask = in_access ? wmask : '0;
  assign mem.mem_waddr = in_access ? {addr_q[REG_BUS-1:2], 2'b00} : '0;
  assign mem.mem_raddr = in_access ? {addr_q[REG_BUS-1:2], 2'b00} : '0;
  assign mem.mem_wdata = in_access ? wdata_sh : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: two instances (1 and 3 access cycles) share the
// request inputs and a common memory read word.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_word;

  logic        ready1, rv1, err1;
  logic [31:0] rd1;
  logic        ready3, rv3, err3;
  logic [31:0] rd3;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_if m1();
  lsu_if m3();

  assign m1.mem_rdata = mem_word;
  assign m3.mem_rdata = mem_word;

  always #5 clk = ~clk;

  lsu #(.ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
    .mem(m1)
  );

  lsu #(.ACCESS_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3),
    .mem(m3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the negedge of cycle 1 with
  // the request inputs scrambled so late sampling would be visible.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    step(1);
    req_valid    = 1'b0;
    req_is_store = ~st;
    req_funct3   = 3'b111;
    req_addr     = 32'h5555_5557;
    req_wdata    = 32'hA5A5_A5A5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_word = '0;
    step(3);
    // reset state
    chk("rst_ready1", {31'd0, ready1}, 32'd1);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);
    chk("rst_rv1",    {31'd0, rv1},    32'd0);
    chk("rst_rd1",    rd1,             32'd0);
    chk("rst_err1",   {31'd0, err1},   32'd0);
    chk("rst_mvalid", {31'd0, m1.mem_valid}, 32'd0);
    chk("rst_waddr",  m1.mem_waddr,    32'd0);
    chk("rst_wmask",  {24'd0, m3.mem_wmask}, 32'd0);
    rst = 1'b0;
    step(1);

    // LW aligned
    mem_word = 32'hDEAD_BEEF;
    issue(1'b0, 3'b010, 32'h8000_0004, 32'd0);
    chk("lw_c1_valid", {31'd0, m1.mem_valid}, 32'd1);
    chk("lw_c1_raddr", m1.mem_raddr, 32'h8000_0004);
    chk("lw_c1_wen",   {31'd0, m1.mem_wen}, 32'd0);
    chk("lw_c1_ready", {31'd0, ready1}, 32'd0);
    chk("lw_c1_rv",    {31'd0, rv1}, 32'd0);
    step(1);
    chk("lw_c2_valid", {31'd0, m1.mem_valid}, 32'd0);
    chk("lw_c2_rv",    {31'd0, rv1}, 32'd1);
    chk("lw_c2_rd",    rd1, 32'hDEAD_BEEF);
    chk("lw_c2_err",   {31'd0, err1}, 32'd0);
    step(1);
    chk("lw_c3_rv",    {31'd0, rv1}, 32'd0);
    chk("lw_c3_ready", {31'd0, ready1}, 32'd1);
    chk("lw3_c3_valid", {31'd0, m3.mem_valid}, 32'd1);
    step(1);
    chk("lw3_c4_rv",   {31'd0, rv3}, 32'd1);
    chk("lw3_c4_rd",   rd3, 32'hDEAD_BEEF);
    step(1);

    // LB / LBU on the top byte
    mem_word = 32'h8012_3456;
    issue(1'b0, 3'b000, 32'h8000_0003, 32'd0);
    step(1);
    chk("lb_rv", {31'd0, rv1}, 32'd1);
    chk("lb_rd", rd1, 32'hFFFF_FF80);
    step(3);
    issue(1'b0, 3'b100, 32'h8000_0003, 32'd0);
    step(1);
    chk("lbu_rd", rd1, 32'h0000_0080);
    step(2);
    chk("lbu3_rd", rd3, 32'h0000_0080);
    step(1);

    // LH / LHU on the upper half
    mem_word = 32'hF00D_1234;
    issue(1'b0, 3'b001, 32'h8000_0002, 32'd0);
    step(1);
    chk("lh_rd", rd1, 32'hFFFF_F00D);
    step(3);
    issue(1'b0, 3'b101, 32'h8000_0002, 32'd0);
    step(1);
    chk("lhu_rd", rd1, 32'h0000_F00D);
    step(3);

    // SH to upper half
    issue(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
    chk("sh_wen",   {31'd0, m1.mem_wen}, 32'd1);
    chk("sh_wmask", {24'd0, m1.mem_wmask}, 32'h0000_000C);
    chk("sh_wdata", m1.mem_wdata, 32'hABCD_ABCD);
    chk("sh_waddr", m1.mem_waddr, 32'h8000_0000);
    step(1);
    chk("sh_rv",  {31'd0, rv1}, 32'd1);
    chk("sh_rd",  rd1, 32'd0);
    chk("sh_err", {31'd0, err1}, 32'd0);
    step(3);

    // SB to lane 1
    issue(1'b1, 3'b000, 32'h8000_0101, 32'h0000_00CD);
    chk("sb_wmask", {24'd0, m1.mem_wmask}, 32'h0000_0002);
    chk("sb_wdata", m1.mem_wdata, 32'hCDCD_CDCD);
    chk("sb_waddr", m1.mem_waddr, 32'h8000_0100);
    step(4);

    // Misaligned LW
    issue(1'b0, 3'b010, 32'h8000_0001, 32'd0);
    chk("mis_valid1", {31'd0, m1.mem_valid}, 32'd0);
    chk("mis_valid3", {31'd0, m3.mem_valid}, 32'd0);
    chk("mis_rv",     {31'd0, rv1}, 32'd1);
    chk("mis_err",    {31'd0, err1}, 32'd1);
    chk("mis_rd",     rd1, 32'd0);
    chk("mis_err3",   {31'd0, err3}, 32'd1);
    step(1);
    chk("mis_c2_rv",    {31'd0, rv1}, 32'd0);
    chk("mis_c2_ready", {31'd0, ready1}, 32'd1);

    // Illegal load funct3
    issue(1'b0, 3'b011, 32'h8000_0000, 32'd0);
    chk("ill_valid", {31'd0, m1.mem_valid}, 32'd0);
    chk("ill_rv",    {31'd0, rv1}, 32'd1);
    chk("ill_err",   {31'd0, err1}, 32'd1);
    step(1);

    // Illegal store funct3
    issue(1'b1, 3'b100, 32'h8000_0000, 32'd0);
    chk("ills_valid", {31'd0, m3.mem_valid}, 32'd0);
    chk("ills_err",   {31'd0, err3}, 32'd1);
    step(1);

    // SW with 3 access cycles
    issue(1'b1, 3'b010, 32'h8000_0010, 32'h1122_3344);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("sw3_c%0d_valid", c), {31'd0, m3.mem_valid}, 32'd1);
      chk($sformatf("sw3_c%0d_waddr", c), m3.mem_waddr, 32'h8000_0010);
      chk($sformatf("sw3_c%0d_wmask", c), {24'd0, m3.mem_wmask}, 32'h0000_000F);
      chk($sformatf("sw3_c%0d_wdata", c), m3.mem_wdata, 32'h1122_3344);
      chk($sformatf("sw3_c%0d_ready", c), {31'd0, ready3}, 32'd0);
      chk($sformatf("sw3_c%0d_rv", c),    {31'd0, rv3}, 32'd0);
      step(1);
    end
    chk("sw3_c4_rv",    {31'd0, rv3}, 32'd1);
    chk("sw3_c4_valid", {31'd0, m3.mem_valid}, 32'd0);
    chk("sw3_c4_ready", {31'd0, ready3}, 32'd0);
    chk("sw3_c4_rd",    rd3, 32'd0);
    step(1);
    chk("sw3_c5_ready", {31'd0, ready3}, 32'd1);

    // Reset during a 3-cycle load
    mem_word = 32'h0BAD_0BAD;
    issue(1'b0, 3'b010, 32'h8000_0008, 32'd0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstmid_valid", {31'd0, m3.mem_valid}, 32'd0);
    chk("rstmid_rv",    {31'd0, rv3}, 32'd0);
    chk("rstmid_ready", {31'd0, ready3}, 32'd1);
    chk("rstmid_rd",    rd3, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk($sformatf("rstmid_norsp%0d", c), {31'd0, rv3}, 32'd0);
    end

    // New LW after the abort
    mem_word = 32'hCAFE_F00D;
    issue(1'b0, 3'b010, 32'h8000_000C, 32'd0);
    chk("post_raddr", m3.mem_raddr, 32'h8000_000C);
    step(3);
    chk("post_rv",  {31'd0, rv3}, 32'd1);
    chk("post_rd",  rd3, 32'hCAFE_F00D);
    chk("post_err", {31'd0, err3}, 32'd0);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
